// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ==========================================================================
// uart_cmd_pkg - states, ASCII constants and hex helpers for uart_cmd_parser
// Rev 1.0
// ==========================================================================
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR_HI  = 4'd1,
    ST_ADDR_LO  = 4'd2,
    ST_DATA_HI  = 4'd3,
    ST_DATA_LO  = 4'd4,
    ST_WAIT_EOL = 4'd5,
    ST_DISCARD  = 4'd6,
    ST_EXEC     = 4'd7,
    ST_RD_CAP   = 4'd8,
    ST_RESP     = 4'd9
  } state_t;

  localparam logic [7:0] c_cr = 8'h0D;
  localparam logic [7:0] c_lf = 8'h0A;
  localparam logic [7:0] c_w  = 8'h57;
  localparam logic [7:0] c_r  = 8'h52;
  localparam logic [7:0] c_k  = 8'h4B;
  localparam logic [7:0] c_qm = 8'h3F;

  // Returns {valid, nibble}; accepts 0-9, A-F, a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] ch);
    logic [4:0] res;
    res = 5'b0;
    if (ch >= 8'h30 && ch <= 8'h39)
      res = {1'b1, ch[3:0]};
    else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
      res = {1'b1, ch[3:0] + 4'd9};
    return res;
  endfunction

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_resp_buf.sv
`default_nettype none
// ==========================================================================
// uart_cmd_resp_buf - parallel-load response queue (up to 4 bytes), byte 0
// in i_bytes[7:0], valid/ready output.  Rev 1.0
// ==========================================================================
module uart_cmd_resp_buf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_bytes,
  input  logic [2:0]  i_len,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done
);

  logic [31:0] r_shift;
  logic [2:0]  r_cnt;
  logic        w_xfer;

  assign w_xfer    = o_tx_valid && i_tx_ready;
  assign o_done    = w_xfer && (r_cnt == 3'd1);
  // Head byte always sits in the low lane so the output is a plain flop.
  assign o_tx_data = r_shift[7:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift    <= 32'h0;
      r_cnt      <= 3'd0;
      o_tx_valid <= 1'b0;
    end else if (i_load) begin
      r_shift    <= i_bytes;
      r_cnt      <= i_len;
      o_tx_valid <= (i_len != 3'd0);
    end else if (w_xfer) begin
      r_shift    <= {8'h00, r_shift[31:8]};
      r_cnt      <= r_cnt - 3'd1;
      o_tx_valid <= (r_cnt != 3'd1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ==========================================================================
// uart_cmd_parser - ASCII W/R command parser driving a register bus; idle
// timeout on partial commands when UART_CMD_TIMEOUT_EN is defined.  Rev 1.0
// ==========================================================================
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_wr,
  output logic       o_reg_rd,
  input  logic [7:0] i_reg_rdata,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy
);

  state_t      r_state, w_state_nxt;
  logic        r_is_wr;
  logic [7:0]  r_addr_sr, r_data_sr;
  logic [4:0]  w_hex;
  logic        w_hex_ok, w_is_term, w_is_w, w_is_r;
  logic        w_load, w_resp_done, w_timeout, w_exec_nxt;
  logic [31:0] w_resp_bytes;
  logic [2:0]  w_resp_len;

  assign w_hex     = hex_decode(i_rx_data);
  assign w_hex_ok  = w_hex[4];
  assign w_is_term = (i_rx_data == c_cr) || (i_rx_data == c_lf);
  // Bit 5 folds case for the two command letters.
  assign w_is_w    = ((i_rx_data | 8'h20) == (c_w | 8'h20));
  assign w_is_r    = ((i_rx_data | 8'h20) == (c_r | 8'h20));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_resp_bytes = {8'h00, c_lf, c_cr, c_qm};
    w_resp_len   = 3'd3;
    unique case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (w_is_w || w_is_r) w_state_nxt = ST_ADDR_HI;
          else if (!w_is_term)  w_state_nxt = ST_DISCARD;
        end
      end
      ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO: begin
        if (i_rx_valid) begin
          if (w_is_term) begin
            w_state_nxt = ST_RESP;
            w_load      = 1'b1;
          end else if (!w_hex_ok) begin
            w_state_nxt = ST_DISCARD;
          end else if (r_state == ST_ADDR_HI) begin
            w_state_nxt = ST_ADDR_LO;
          end else if (r_state == ST_ADDR_LO) begin
            w_state_nxt = r_is_wr ? ST_DATA_HI : ST_WAIT_EOL;
          end else if (r_state == ST_DATA_HI) begin
            w_state_nxt = ST_DATA_LO;
          end else begin
            w_state_nxt = ST_WAIT_EOL;
          end
        end
      end
      ST_WAIT_EOL: begin
        if (i_rx_valid) w_state_nxt = w_is_term ? ST_EXEC : ST_DISCARD;
      end
      ST_DISCARD: begin
        if (i_rx_valid && w_is_term) begin
          w_state_nxt = ST_RESP;
          w_load      = 1'b1;
        end
      end
      ST_EXEC: begin
        if (r_is_wr) begin
          w_state_nxt  = ST_RESP;
          w_load       = 1'b1;
          w_resp_bytes = {8'h00, c_lf, c_cr, c_k};
        end else begin
          w_state_nxt = ST_RD_CAP;
        end
      end
      ST_RD_CAP: begin
        w_state_nxt  = ST_RESP;
        w_load       = 1'b1;
        w_resp_bytes = {c_lf, c_cr, nib_to_ascii(i_reg_rdata[3:0]),
                        nib_to_ascii(i_reg_rdata[7:4])};
        w_resp_len   = 3'd4;
      end
      ST_RESP: begin
        if (w_resp_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) w_state_nxt = ST_IDLE;
  end

  assign w_exec_nxt = (w_state_nxt == ST_EXEC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_wr   <= 1'b0;
      r_addr_sr <= 8'h00;
      r_data_sr <= 8'h00;
    end else if (i_rx_valid) begin
      if (r_state == ST_IDLE) r_is_wr <= w_is_w;
      if ((r_state == ST_ADDR_HI || r_state == ST_ADDR_LO) && w_hex_ok)
        r_addr_sr <= {r_addr_sr[3:0], w_hex[3:0]};
      if ((r_state == ST_DATA_HI || r_state == ST_DATA_LO) && w_hex_ok)
        r_data_sr <= {r_data_sr[3:0], w_hex[3:0]};
    end
  end

  // Bus outputs change only when a complete command is committed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_reg_addr  <= 8'h00;
      o_reg_wdata <= 8'h00;
      o_reg_wr    <= 1'b0;
      o_reg_rd    <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_reg_wr <= w_exec_nxt && r_is_wr;
      o_reg_rd <= w_exec_nxt && !r_is_wr;
      o_busy   <= (w_state_nxt == ST_EXEC) || (w_state_nxt == ST_RD_CAP) ||
                  (w_state_nxt == ST_RESP);
      if (w_exec_nxt) begin
        o_reg_addr <= r_addr_sr;
        if (r_is_wr) o_reg_wdata <= r_data_sr;
      end
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int c_tmo_cycles = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int c_tmo_w      = $clog2(c_tmo_cycles);

  logic [c_tmo_w-1:0] r_tmo_cnt;
  logic               w_collecting;

  assign w_collecting = (r_state == ST_ADDR_HI) || (r_state == ST_ADDR_LO) ||
                        (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO) ||
                        (r_state == ST_WAIT_EOL) || (r_state == ST_DISCARD);
  assign w_timeout = w_collecting && !i_rx_valid &&
                     (r_tmo_cnt == c_tmo_w'(c_tmo_cycles - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        r_tmo_cnt <= '0;
    else if (!w_collecting || i_rx_valid) r_tmo_cnt <= '0;
    else                                 r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  logic w_cfg_unused;
  assign w_cfg_unused = ((CLK_FREQ + TIMEOUT_MS) != 0);
  assign w_timeout    = 1'b0;
`endif

  uart_cmd_resp_buf u_resp_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_bytes    (w_resp_bytes),
    .i_len      (w_resp_len),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (w_resp_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ==========================================================================
// tb_uart_cmd_parser - line-level reference model with per-cycle compare.
// Rev 1.0
// ==========================================================================
module tb_uart_cmd_parser;

  localparam int CLK_FREQ   = 1000;
  localparam int TIMEOUT_MS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] reg_addr, reg_wdata, reg_rdata, tx_data;
  logic       reg_wr, reg_rd, tx_valid, busy;
  logic       tx_ready = 1'b1;

  always #5 clk = ~clk;

  uart_cmd_parser #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata), .o_reg_wr(reg_wr),
    .o_reg_rd(reg_rd), .i_reg_rdata(reg_rdata), .o_tx_data(tx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_busy(busy)
  );

  function automatic logic [7:0] reg_model(input logic [7:0] a);
    return (a == 8'h3C) ? 8'h7E : (a * 8'd7 + 8'd3);
  endfunction
  assign reg_rdata = reg_model(reg_addr);

  typedef struct packed {
    logic        is_wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } strobe_t;

  int         n_vec = 0, n_err = 0, cyc = 0;
  strobe_t    exp_strobe_q[$];
  logic [7:0] exp_tx_q[$];
  int         exp_first_q[$];
  logic [7:0] line_q[$];
  logic [7:0] tx_log[$];
  bit         pending = 0, started = 0, stalled = 0;
  int         busy_start = 0;
  logic [7:0] prev_data = 8'h00;
  int         n_wr_seen = 0, n_rd_seen = 0;
  logic [7:0] last_wr_addr = 8'h00, last_wr_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit hexv(input logic [7:0] c, output logic [3:0] v);
    v = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin v = c[3:0]; return 1'b1; end
    if (c >= 8'h41 && c <= 8'h46) begin v = 4'(c - 8'h41 + 8'd10); return 1'b1; end
    if (c >= 8'h61 && c <= 8'h66) begin v = 4'(c - 8'h61 + 8'd10); return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  // A terminated non-empty line yields one command or one '?' response.
  task automatic model_term(input int t);
    logic [3:0] n0, n1, n2, n3;
    logic [7:0] d;
    bit         ok;
    strobe_t    s;
    if (line_q.size() == 0) return;
    pending    = 1;
    busy_start = t + 1;
    ok = 0;
    if (line_q.size() == 5 && (line_q[0] == "W" || line_q[0] == "w"))
      ok = hexv(line_q[1], n0) && hexv(line_q[2], n1) && hexv(line_q[3], n2) && hexv(line_q[4], n3);
    if (ok) begin
      s.is_wr = 1'b1; s.addr = {n0, n1}; s.data = {n2, n3}; s.cyc = 32'(t + 1);
      exp_strobe_q.push_back(s);
      exp_tx_q.push_back(8'h4B); exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'h0A);
      exp_first_q.push_back(t + 2);
      return;
    end
    if (line_q.size() == 3 && (line_q[0] == "R" || line_q[0] == "r"))
      ok = hexv(line_q[1], n0) && hexv(line_q[2], n1);
    if (ok) begin
      s.is_wr = 1'b0; s.addr = {n0, n1}; s.data = 8'h00; s.cyc = 32'(t + 1);
      exp_strobe_q.push_back(s);
      d = reg_model({n0, n1});
      exp_tx_q.push_back(asc(d[7:4])); exp_tx_q.push_back(asc(d[3:0]));
      exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'h0A);
      exp_first_q.push_back(t + 3);
      return;
    end
    exp_tx_q.push_back(8'h3F); exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'h0A);
    exp_first_q.push_back(t + 1);
  endtask

  task automatic model_reset();
    exp_strobe_q.delete(); exp_tx_q.delete(); exp_first_q.delete(); line_q.delete();
    pending = 0; started = 0; stalled = 0;
  endtask

  always @(negedge clk) begin
    strobe_t s;
    if (rst_n) begin
      chk("busy", busy, pending && (cyc >= busy_start));
      if (reg_wr || reg_rd) begin
        if (reg_wr) begin n_wr_seen++; last_wr_addr = reg_addr; last_wr_data = reg_wdata; end
        if (reg_rd) n_rd_seen++;
        if (exp_strobe_q.size() == 0) chk("strobe_unexpected", {reg_wr, reg_rd}, 0);
        else begin
          s = exp_strobe_q.pop_front();
          chk("strobe_kind", {reg_wr, reg_rd}, s.is_wr ? 2 : 1);
          chk("strobe_cycle", cyc, s.cyc);
          chk("reg_addr", reg_addr, s.addr);
          if (s.is_wr) chk("reg_wdata", reg_wdata, s.data);
        end
      end else if (exp_strobe_q.size() != 0 && exp_strobe_q[0].cyc < cyc) begin
        s = exp_strobe_q.pop_front();
        chk("strobe_missing", {reg_wr, reg_rd}, s.is_wr ? 2 : 1);
      end
      if (tx_valid) begin
        if (!started) begin
          if (exp_first_q.size() == 0) chk("tx_unexpected", tx_valid, 0);
          else begin chk("tx_first_cycle", cyc, exp_first_q.pop_front()); started = 1; end
        end
        if (stalled) chk("tx_hold", tx_data, prev_data);
        if (tx_ready) begin
          tx_log.push_back(tx_data);
          stalled = 0;
          if (exp_tx_q.size() == 0) chk("tx_extra", tx_valid & tx_ready, 0);
          else begin
            chk("tx_data", tx_data, exp_tx_q.pop_front());
            if (exp_tx_q.size() == 0) begin started = 0; pending = 0; end
          end
        end else begin
          stalled = 1; prev_data = tx_data;
        end
      end else begin
        if (stalled) chk("tx_valid_hold", tx_valid, 1);
        stalled = 0;
        if (!started && exp_first_q.size() != 0 && exp_first_q[0] < cyc) begin
          void'(exp_first_q.pop_front());
          chk("tx_late", tx_valid, 1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    if (!(pending && (cyc >= busy_start))) begin
      if (b == 8'h0D || b == 8'h0A) begin model_term(cyc); line_q.delete(); end
      else line_q.push_back(b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; rx_valid = 1'b0; end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((pending || exp_strobe_q.size() != 0 || exp_tx_q.size() != 0) && n < 300) begin
      idle(1); n++;
    end
    chk({name, "_complete"}, n < 300, 1);
    idle(2);
  endtask

  task automatic begin_test();
    tx_log.delete(); n_wr_seen = 0; n_rd_seen = 0;
  endtask

  task automatic check_log(input string name, input logic [31:0] exp, input int len, input int wr, input int rd);
    chk({name, "_len"}, tx_log.size(), len);
    for (int i = 0; i < len && i < tx_log.size(); i++)
      chk({name, "_byte"}, tx_log[i], exp[8*(len-1-i) +: 8]);
    chk({name, "_wr_count"}, n_wr_seen, wr);
    chk({name, "_rd_count"}, n_rd_seen, rd);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    idle(3);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_rd", reg_rd, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    begin_test(); send_str("W3CA5"); send_byte(8'h0D); wait_done("write");
    check_log("write", 32'h004B0D0A, 3, 1, 0);
    chk("write_addr_lit", last_wr_addr, 8'h3C);
    chk("write_data_lit", last_wr_data, 8'hA5);

    begin_test(); send_str("r3c"); send_byte(8'h0A); wait_done("read");
    check_log("read", 32'h37450D0A, 4, 0, 1);

    begin_test(); send_str("W1G"); send_byte(8'h0D); wait_done("bad_digit");
    check_log("bad_digit", 32'h003F0D0A, 3, 0, 0);

    begin_test(); send_str("R5"); send_byte(8'h0D); wait_done("short");
    check_log("short", 32'h003F0D0A, 3, 0, 0);

    begin_test(); send_str("w0aFf"); send_byte(8'h0D); send_byte(8'h0A); wait_done("lower_crlf");
    check_log("lower_crlf", 32'h004B0D0A, 3, 1, 0);
    chk("lower_addr_lit", last_wr_addr, 8'h0A);
    chk("lower_data_lit", last_wr_data, 8'hFF);

    begin_test(); send_str("W12345"); send_byte(8'h0D); wait_done("too_long");
    check_log("too_long", 32'h003F0D0A, 3, 0, 0);

    begin_test(); send_str("X"); send_byte(8'h0D); wait_done("bad_cmd");
    check_log("bad_cmd", 32'h003F0D0A, 3, 0, 0);

    begin_test(); send_str("RA5"); send_byte(8'h0D); wait_done("read_a5");
    check_log("read_a5", 32'h38360D0A, 4, 0, 1);

    // Stall with bytes injected while the response is held.
    begin_test(); tx_ready = 1'b0;
    send_str("R3C"); send_byte(8'h0D);
    idle(10); send_str("W0"); idle(38);
    chk("stall_data_lit", tx_data, 8'h37);
    chk("stall_valid_lit", tx_valid, 1);
    chk("stall_busy_lit", busy, 1);
    @(posedge clk); #1; tx_ready = 1'b1;
    wait_done("stall");
    check_log("stall", 32'h37450D0A, 4, 0, 1);

    // Reset in the middle of a response.
    begin_test(); tx_ready = 1'b0;
    send_str("RA5"); send_byte(8'h0D); idle(6);
    rst_n = 1'b0; model_reset();
    idle(2);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_reg_addr", reg_addr, 0);
    rst_n = 1'b1; tx_ready = 1'b1; idle(2);
    begin_test(); send_str("W0102"); send_byte(8'h0D); wait_done("after_rst");
    check_log("after_rst", 32'h004B0D0A, 3, 1, 0);

`ifdef UART_CMD_TIMEOUT_EN
    begin_test(); send_str("W12"); idle(10); line_q.delete();
    send_str("R12"); send_byte(8'h0D); wait_done("timeout");
    check_log("timeout", 32'h38310D0A, 4, 0, 1);
`else
    begin_test(); send_str("W12"); idle(50);
    send_str("34"); send_byte(8'h0D); wait_done("persist");
    check_log("persist", 32'h004B0D0A, 3, 1, 0);
    chk("persist_addr_lit", last_wr_addr, 8'h12);
    chk("persist_data_lit", last_wr_data, 8'h34);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

ASCII command parser sitting directly downstream of the 8N1 UART receiver. It consumes received bytes (`i_rx_data`/`i_rx_valid`) and decodes text commands into single-cycle register-bus read and write strobes. It formats a short ASCII response toward the UART transmitter over a valid/ready byte handshake, giving a host terminal peek/poke access to an 8-bit register space.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz; used only for the timeout.
- `TIMEOUT_MS`, default 100: idle time in ms after which a partial command is discarded.
- `i_clk` input 1: single clock domain.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_rx_data` input 8: received byte; valid only when `i_rx_valid` is high.
- `i_rx_valid` input 1: one-cycle pulse per received byte.
- `o_reg_addr` output 8: register address; stable from the strobe until the next command.
- `o_reg_wdata` output 8: write data; stable alongside `o_reg_addr`.
- `o_reg_wr` output 1: one-cycle write strobe.
- `o_reg_rd` output 1: one-cycle read strobe.
- `i_reg_rdata` input 8: read data, sampled the cycle after `o_reg_rd`.
- `o_tx_data` output 8: response byte.
- `o_tx_valid` output 1: response byte valid.
- `i_tx_ready` input 1: transmitter accepts `o_tx_data` when `o_tx_valid` and `i_tx_ready` are both high.
- `o_busy` output 1: high from command execution until the last response byte is accepted.

## Operation
- **Grammar:**
  - Write is `W`, then 4 hex digits (AA DD), then a terminator.
  - Read is `R`, then 2 hex digits (AA), then a terminator.
  - Command letters and hex digits are case-insensitive. A terminator is CR (0x0D) or LF (0x0A).
- **States:** IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_EOL, DISCARD, EXEC, RD_CAP, RESP.
- **IDLE:**
  - `W` or `R` latches the op and goes to ADDR_HI.
  - A terminator is ignored, so CRLF pairs are harmless.
  - Any other byte goes to DISCARD.
- **Digit collection:**
  - Each valid hex digit shifts into the address or data nibble and advances the state: ADDR_HI → ADDR_LO → (DATA_HI → DATA_LO for writes) → WAIT_EOL.
  - A non-hex byte goes to DISCARD.
  - A terminator received before the digits are complete queues an error and goes to RESP.
- **WAIT_EOL:**
  - A terminator goes to EXEC.
  - Any other byte goes to DISCARD.
- **DISCARD:** drops bytes until a terminator, then queues `?` CR LF and goes to RESP.
- **EXEC:**
  - Write: pulse `o_reg_wr`, queue `K` CR LF, go to RESP.
  - Read: pulse `o_reg_rd`, go to RD_CAP.
- **RD_CAP:** capture `i_reg_rdata`, queue two uppercase hex digits (high nibble first) plus CR LF, go to RESP.
- **RESP:**
  - Present the queued bytes in order.
  - Advance only on a valid&ready transfer; `o_tx_data` holds stable while stalled.
  - After the last byte, return to IDLE.
- **Bytes during execution:** any `i_rx_valid` in EXEC, RD_CAP or RESP is dropped with no side effect.
- **Reset (mid-command or mid-response):** returns to IDLE immediately; a half-sent response is abandoned.
- **Reset values:** `o_reg_addr`=0, `o_reg_wdata`=0, `o_reg_wr`=0, `o_reg_rd`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0.

## Timing
- Let T be the cycle in which the terminator is sampled with `i_rx_valid`.
- **Write:** `o_reg_wr` is high in T+1. `o_tx_valid` carrying `K` is high from T+2.
- **Read:** `o_reg_rd` is high in T+1. `i_reg_rdata` is sampled in T+2. `o_tx_valid` carrying the high-nibble digit is high from T+3.
- **Error:** `o_tx_valid` carrying `?` is high from T+1.
- **Back-to-back responses:** with `i_tx_ready` held high, consecutive response bytes transfer on consecutive cycles.
- **`o_busy`:** high from T+1 until the cycle after the final transfer.
- **Registered outputs:** all outputs come directly from flops; there is no combinational path from rx inputs to any output.

## Configuration
- **`UART_CMD_TIMEOUT_EN` defined:**
  - A counter of width $clog2(CLK_FREQ/1000*TIMEOUT_MS) clears on every accepted byte.
  - In ADDR_HI..WAIT_EOL or DISCARD, reaching CLK_FREQ/1000*TIMEOUT_MS−1 returns the parser silently to IDLE, with no response.
  - The counter is inactive in IDLE, EXEC, RD_CAP and RESP.
- **Macro undefined:** there is no counter, and a partial command persists indefinitely. `TIMEOUT_MS` is ignored.

## Structure
- **Package `uart_cmd_pkg`:**
  - The state enum.
  - ASCII constants: CR, LF, `W`, `R`, `K`, `?`.
  - Hex-to-nibble decode function, returning a valid flag and the nibble.
  - Nibble-to-uppercase-ASCII function.
- **Sub-module `uart_cmd_resp_buf`:**
  - Up to 4-byte load-parallel response queue with a length field.
  - Valid/ready output; reports done to the FSM.
  - Instantiated once.

## Test plan
- **Write:** `W3CA5` CR (`i_tx_ready`=1) → `o_reg_wr` pulses once with addr=0x3C, wdata=0xA5, T+1; tx emits 0x4B 0x0D 0x0A.
- **Read:** `r3c` LF, `i_reg_rdata`=0x7E → `o_reg_rd` pulses with addr=0x3C; tx emits `7E` CR LF (0x37 0x45 0x0D 0x0A).
- **Bad digit:** `W1G` CR → no strobes; tx emits `?` CR LF.
- **Short command:** `R5` CR → no strobes; tx emits `?` CR LF.
- **Stall:** hold `i_tx_ready`=0 for 50 cycles during a read response → `o_tx_data` stable, `o_busy` high; bytes injected meanwhile are dropped; full response follows on release.
- **Timeout:** with `UART_CMD_TIMEOUT_EN`, CLK_FREQ=1000, TIMEOUT_MS=10, send `W12`, wait 10 cycles, then `R12` CR → exactly one `o_reg_rd` (addr 0x12) and no `o_reg_wr`.
